// File: rtl/output_port_arbiter.sv
// Wormhole arbiter for one router output port: round-robin grant held until the
// owner's tail flit transfers, with a flit-count watchdog forcing release.
module output_port_arbiter #(
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req_i,
  input  logic [4:0] tail_i,
  input  logic       ready_i,
  output logic [2:0] address_route_o,
  output logic [4:0] grant_o,
  output logic       xfer_o,
  output logic       err_o
);

  localparam int CW = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      owner;
  logic [CW-1:0]   flit_cnt;
  logic [2:0]      pick;
  logic            pick_valid;
  logic [2:0]      cand;
  logic            owner_tail;
  logic            cnt_limit;

  function automatic logic [2:0] wrap_inc(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping modulo 5.
  always_comb begin
    pick       = 3'd0;
    pick_valid = 1'b0;
    cand       = ptr;
    for (int i = 0; i < 5; i++) begin
      if (!pick_valid && req_i[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  // grant_o is one-hot on the owner while LOCKED and zero otherwise.
  assign xfer_o     = (state == LOCKED) && ready_i && |(req_i & grant_o);
  assign owner_tail = |(tail_i & grant_o);
  assign cnt_limit  = (flit_cnt == CW'(MAX_PKT_FLITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= 3'd0;
      owner           <= 3'd0;
      flit_cnt        <= '0;
      grant_o         <= 5'b00000;
      address_route_o <= 3'b111;
      err_o           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state           <= LOCKED;
            owner           <= pick;
            grant_o         <= 5'b00001 << pick;
            address_route_o <= pick;
            flit_cnt        <= '0;
          end
        end
        LOCKED: begin
          if (xfer_o) begin
            // A runaway packet is released exactly as if this flit were its tail.
            if (owner_tail || cnt_limit) begin
              state           <= IDLE;
              grant_o         <= 5'b00000;
              address_route_o <= 3'b111;
              ptr             <= wrap_inc(owner);
              flit_cnt        <= '0;
              if (!owner_tail) err_o <= 1'b1;
            end else begin
              flit_cnt <= flit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: directed packets push expected
// transfers into a queue that a negedge monitor pops whenever xfer_o fires.
module tb_output_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] req_i = '0;
  logic [4:0] tail_i = '0;
  logic       ready_i = 1'b0;
  logic [2:0] address_route_o;
  logic [4:0] grant_o;
  logic       xfer_o;
  logic       err_o;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct packed {
    logic [2:0] route;
    logic [4:0] grant;
  } xfer_t;

  xfer_t exp_q[$];

  output_port_arbiter #(.MAX_PKT_FLITS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .tail_i          (tail_i),
    .ready_i         (ready_i),
    .address_route_o (address_route_o),
    .grant_o         (grant_o),
    .xfer_o          (xfer_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  // Monitor: every transfer must match the head of the expected queue, and an
  // expected transfer scheduled for this cycle must actually happen.
  always @(negedge clk) begin
    if (rst_n) begin
      if (xfer_o) begin
        n_compared++;
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("[TB] FAIL xfer_unexpected: got route=%b grant=%b, wanted no transfer", address_route_o, grant_o);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          if (address_route_o !== e.route || grant_o !== e.grant) begin
            n_mismatched++;
            $display("[TB] FAIL xfer_owner: got route=%b grant=%b, wanted route=%b grant=%b",
                     address_route_o, grant_o, e.route, e.grant);
          end
        end
      end else if (exp_q.size() > 0) begin
        xfer_t e;
        e = exp_q.pop_front();
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL xfer_missing: got xfer_o=0, wanted transfer route=%b grant=%b", e.route, e.grant);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] req, input logic [4:0] tail, input logic ready);
    req_i   = req;
    tail_i  = tail;
    ready_i = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic expectXfer(input logic [2:0] route, input logic [4:0] grant);
    xfer_t e;
    e.route = route;
    e.grant = grant;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] route,
                             input logic [4:0] grant, input logic err);
    n_compared++;
    if (address_route_o !== route || grant_o !== grant || err_o !== err) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got route=%b grant=%b err=%b, wanted route=%b grant=%b err=%b",
               name, address_route_o, grant_o, err_o, route, grant, err);
    end
  endtask

  task automatic doReset();
    req_i   = '0;
    tail_i  = '0;
    ready_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("reset_values", 3'b111, 5'b00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [4:0] one_hot;
    #3;
    doReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'b00000, 5'b00000, 1'b1);
      checkOutput("idle_hold", 3'b111, 5'b00000, 1'b0);
    end

    // Single requester E, three flits, tail on the third.
    applyStimulus(5'b00100, 5'b00000, 1'b1);
    checkOutput("single_grant_e", 3'b010, 5'b00100, 1'b0);
    expectXfer(3'b010, 5'b00100);
    applyStimulus(5'b00100, 5'b00000, 1'b1);
    checkOutput("single_flit1", 3'b010, 5'b00100, 1'b0);
    expectXfer(3'b010, 5'b00100);
    applyStimulus(5'b00100, 5'b00000, 1'b1);
    expectXfer(3'b010, 5'b00100);
    applyStimulus(5'b00100, 5'b00100, 1'b1);
    checkOutput("single_release", 3'b111, 5'b00000, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 1'b1);

    // Fairness from ptr=N: all request single-flit packets.
    doReset();
    for (int k = 0; k < 6; k++) begin
      logic [2:0] r;
      r = 3'(k % 5);
      one_hot = 5'b00001 << r;
      applyStimulus(5'b11111, 5'b11111, 1'b1);
      checkOutput("rr_grant", r, one_hot, 1'b0);
      expectXfer(r, one_hot);
      applyStimulus(5'b11111, 5'b11111, 1'b1);
      checkOutput("rr_bubble", 3'b111, 5'b00000, 1'b0);
    end
    applyStimulus(5'b00000, 5'b00000, 1'b1);

    // Backpressure and wormhole gap on owner W (ptr is now S).
    applyStimulus(5'b01000, 5'b00000, 1'b1);
    checkOutput("bp_grant_w", 3'b011, 5'b01000, 1'b0);
    expectXfer(3'b011, 5'b01000);
    applyStimulus(5'b01000, 5'b00000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'b11111, 5'b11111, 1'b0);
      checkOutput("bp_hold", 3'b011, 5'b01000, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(5'b10111, 5'b11111, 1'b1);
      checkOutput("gap_hold", 3'b011, 5'b01000, 1'b0);
    end
    expectXfer(3'b011, 5'b01000);
    applyStimulus(5'b01000, 5'b01000, 1'b1);
    checkOutput("bp_release", 3'b111, 5'b00000, 1'b0);

    // Watchdog: owner S sends 4 flits, non-owner tails set but ignored.
    applyStimulus(5'b00010, 5'b11101, 1'b1);
    checkOutput("wd_grant_s", 3'b001, 5'b00010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expectXfer(3'b001, 5'b00010);
      applyStimulus(5'b00010, 5'b11101, 1'b1);
      checkOutput("wd_still_locked", 3'b001, 5'b00010, 1'b0);
    end
    expectXfer(3'b001, 5'b00010);
    applyStimulus(5'b00010, 5'b11101, 1'b1);
    checkOutput("wd_forced_release", 3'b111, 5'b00000, 1'b1);
    applyStimulus(5'b11111, 5'b11111, 1'b1);
    checkOutput("wd_next_grant_e", 3'b010, 5'b00100, 1'b1);
    expectXfer(3'b010, 5'b00100);
    applyStimulus(5'b11111, 5'b11111, 1'b1);
    checkOutput("wd_err_sticky", 3'b111, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b1);

    // Reset mid-packet: owner N (ptr is W, so N is found after wrap).
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    checkOutput("mid_grant_n", 3'b000, 5'b00001, 1'b1);
    expectXfer(3'b000, 5'b00001);
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    expectXfer(3'b000, 5'b00001);
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    doReset();
    applyStimulus(5'b00011, 5'b00000, 1'b1);
    checkOutput("post_reset_grant_n", 3'b000, 5'b00001, 1'b0);
    expectXfer(3'b000, 5'b00001);
    applyStimulus(5'b00011, 5'b00001, 1'b1);
    checkOutput("post_reset_release", 3'b111, 5'b00000, 1'b0);
    applyStimulus(5'b00000, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b1);

    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL queue_drained: got %0d pending transfers, wanted 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port wormhole arbiter for the 5-port mesh router. Arbitrates among input ports (N, S, E, W, Local) requesting the same output. It produces the registered 3-bit route select that drives that output's data and valid muxes. It holds the grant until the owning packet's tail flit transfers. Round-robin fairness across packets, plus a flit-count watchdog that forces release on runaway packets.

## Interface
- MAX_PKT_FLITS, 16, maximum flits per packet before forced release (≥ 1)
- clk  input  1  router clock
- rst_n  input  1  asynchronous active-low reset
- req_i  input  5  per-input request/flit-valid toward this output; bit 0=N, 1=S, 2=E, 3=W, 4=L
- tail_i  input  5  per-input flag: the flit currently presented is a tail flit (same bit order)
- ready_i  input  1  downstream (next router or local sink) can accept a flit this cycle
- address_route_o  output  3  mux select: 000 N, 001 S, 010 E, 011 W, 100 L, 111 none
- grant_o  output  5  one-hot grant to the owning input (same bit order); all-zero when idle
- xfer_o  output  1  a flit transfers this cycle: owner's req_i bit AND ready_i, while LOCKED
- err_o  output  1  sticky: a packet hit MAX_PKT_FLITS without a tail

## Operation
- State machine has two states, IDLE and LOCKED.
  - IDLE, no req_i bits set: stay IDLE.
  - IDLE, any req_i bit set: pick the winner by round-robin search starting at pointer ptr (ptr, ptr+1, … mod 5). Register owner, set grant_o and address_route_o, go to LOCKED.
  - LOCKED: hold owner. A transfer is owner's req_i AND ready_i.
  - LOCKED, transfer with owner's tail_i = 1: release. Go to IDLE, ptr ← (owner+1) mod 5.
  - LOCKED, transfer without tail: increment flit counter, stay LOCKED.
  - LOCKED, owner's req_i low (wormhole gap): hold lock, no transfer, counter unchanged.
  - LOCKED, ready_i low: no transfer, no release, even if tail_i is set.
- Flit counter
  - Width is clog2(MAX_PKT_FLITS+1).
  - Cleared on entry to LOCKED; counts every transfer, including the head.
  - If a transfer makes the count equal MAX_PKT_FLITS and tail_i is 0: force release as if it were a tail (IDLE, ptr advance) and set err_o.
  - err_o is cleared only by reset.
- Requests from non-owners while LOCKED are ignored. They do not affect ptr.
- tail_i bits of non-owners are ignored.
- A single-flit packet (head = tail) locks, transfers once, and releases.

## Timing
- Reset values (asynchronous, on rst_n low):
  - state IDLE, ptr 0 (N), counter 0
  - grant_o 00000, address_route_o 111, err_o 0
- Arbitration latency: a request sampled in IDLE at edge t gives grant_o/address_route_o valid after edge t, usable in cycle t+1.
- Outputs are registered. xfer_o is combinational from registered owner, req_i and ready_i.
- Release: a tail transfer in cycle k returns address_route_o to 111 and grant_o to 0 in cycle k+1. The next grant appears in cycle k+2, a one-cycle bubble by design.
- Round-robin boundary: after owner L (4) releases, ptr wraps to 0 (N).
- rst_n asserted mid-packet: lock dropped immediately and outputs go to reset values. The counter and ptr reset; err_o clears.

## Test plan
- Reset then idle: rst_n low → address_route_o=111, grant_o=00000, err_o=0. After release, req_i=0 for 10 cycles → outputs unchanged.
- Single requester: req_i=00100 (E), tail on 3rd flit, ready_i=1 → address_route_o=010 from next cycle, three xfer_o pulses, then 111 the cycle after the tail.
- Fairness and wrap: req_i=11111 held, every packet 1 flit → grant order N, S, E, W, L, N, each grant separated by one idle (111) cycle.
- Backpressure and gaps: owner W mid-packet, ready_i=0 for 4 cycles with tail_i set, then owner's req_i dropped 2 cycles → address_route_o stays 011, no xfer_o. Release occurs only on the tail cycle with ready_i=1.
- Watchdog: MAX_PKT_FLITS=4, owner S sends 4 flits without tail → forced release after the 4th transfer, err_o=1 and stays 1. The next requester is granted, with ptr at E.
- Reset mid-packet: owner N after 2 flits, rst_n pulse low → immediate 111/00000. After reset, req_i=00011 grants N first (ptr=0).
